// File: rtl/scroll_monitor.sv
// Self-check decoder for the bouncing two-LED scroll pattern: tracks pos/dir, flags illegal steps, counts bounces.
// Optional SCROLL_MON_STICKY_ERR_EN: err latches until reset and freezes tracking.
module scroll_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [7:0]       pattern_in,
    output logic [2:0]       pos,
    output logic             dir,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        ACQ  = 3'd1,
        DOWN = 3'd2,
        UP   = 3'd3,
        TOP  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   bounce_q, bounce_d;

    logic               pat_legal;
    logic [2:0]         pat_p;
    logic               viol;
    logic               frozen;

    always_comb begin
        pat_legal = 1'b0;
        pat_p     = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (pattern_in == (8'h03 << i)) begin
                pat_legal = 1'b1;
                pat_p     = 3'(i);
            end
        end
    end

`ifdef SCROLL_MON_STICKY_ERR_EN
    assign frozen = err_q;
`else
    assign frozen = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        locked_d = locked_q;
        bounce_d = bounce_q;
        viol     = 1'b0;
`ifdef SCROLL_MON_STICKY_ERR_EN
        err_d    = err_q;
`else
        err_d    = 1'b0;
`endif
        if (sample_en && !frozen) begin
            if (state_q == SYNC) begin
                if (pat_legal) begin
                    pos_d    = pat_p;
                    state_d  = ACQ;
                    locked_d = 1'b0;
                end
            end else if (!pat_legal) begin
                viol = 1'b1;
            end else begin
                // A legal-but-wrong p still becomes the new reference position.
                pos_d = pat_p;
                case (state_q)
                    ACQ: begin
                        if (pat_p == pos_q - 3'd1) begin
                            state_d  = (pat_p == 3'd0) ? UP : DOWN;
                            dir_d    = (pat_p == 3'd0);
                            locked_d = 1'b1;
                        end else if (pat_p == pos_q + 3'd1) begin
                            state_d  = (pat_p == 3'd6) ? TOP : UP;
                            dir_d    = 1'b1;
                            locked_d = 1'b1;
                        end else if (pat_p == 3'd6 && pos_q == 3'd6) begin
                            state_d  = DOWN;
                            dir_d    = 1'b0;
                            locked_d = 1'b1;
                        end else begin
                            viol = 1'b1;
                        end
                    end
                    DOWN: begin
                        if (pat_p != pos_q - 3'd1) begin
                            viol = 1'b1;
                        end else if (pat_p == 3'd0) begin
                            state_d  = UP;
                            dir_d    = 1'b1;
                            bounce_d = bounce_q + 1'b1;
                        end
                    end
                    UP: begin
                        if (pat_p != pos_q + 3'd1) begin
                            viol = 1'b1;
                        end else if (pat_p == 3'd6) begin
                            state_d = TOP;
                        end
                    end
                    TOP: begin
                        if (pat_p != 3'd6) begin
                            viol = 1'b1;
                        end else begin
                            state_d  = DOWN;
                            dir_d    = 1'b0;
                            bounce_d = bounce_q + 1'b1;
                        end
                    end
                    default: viol = 1'b1;
                endcase
            end
            if (viol) begin
                err_d    = 1'b1;
                locked_d = 1'b0;
                state_d  = SYNC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SYNC;
            pos_q    <= 3'd0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            bounce_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            bounce_q <= bounce_d;
        end
    end

    assign pos         = pos_q;
    assign dir         = dir_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign bounce_cnt  = bounce_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scroll_monitor.sv
// Directed bench for scroll_monitor: a cycle-position model of the bounce sequence feeds a scoreboard queue.
// A second instance with CNT_W=2 checks bounce counter wrap on the same stimulus.
module tb_scroll_monitor;
    localparam int W = 14;

    logic       clk, reset, sample_en;
    logic [7:0] pattern_in;
    logic [2:0] pos, pos2, dbg_state, dbg_state2;
    logic       dir, locked, err, dir2, locked2, err2;
    logic [7:0] bounce_cnt;
    logic [1:0] bounce_cnt2;

    scroll_monitor #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .pattern_in(pattern_in),
        .pos(pos), .dir(dir), .locked(locked), .err(err),
        .bounce_cnt(bounce_cnt), .dbg_state_o(dbg_state)
    );

    scroll_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .pattern_in(pattern_in),
        .pos(pos2), .dir(dir2), .locked(locked2), .err(err2),
        .bounce_cnt(bounce_cnt2), .dbg_state_o(dbg_state2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // Model: position within the 13-sample cycle 6,5,4,3,2,1,0,1,2,3,4,5,6 (then 6 again).
    int seq[13] = '{6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6};
    int         m_mode;   // 0 sync, 1 acquiring, 2 locked
    int         m_idx;
    logic [2:0] m_pos;
    logic       m_dir, m_locked, m_err, m_frozen;
    logic [7:0] m_bounce;

    function automatic int decode(input logic [7:0] pat);
        if ($countones(pat) != 2 || (pat & (pat >> 1)) == 8'h00) return -1;
        for (int k = 0; k < 8; k++) if (pat[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_pos = 3'd0; m_dir = 1'b0;
        m_locked = 1'b0; m_err = 1'b0; m_frozen = 1'b0; m_bounce = 8'd0;
    endtask

    task automatic model_cycle(input logic en, input logic [7:0] pat);
        int p;
        int nidx;
        bit viol;
`ifndef SCROLL_MON_STICKY_ERR_EN
        m_err = 1'b0;
`endif
        if (!en || m_frozen) return;
        p = decode(pat);
        viol = 1'b0;
        if (m_mode == 0) begin
            if (p >= 0) begin
                m_pos = 3'(p);
                m_mode = 1;
            end
        end else if (p < 0) begin
            viol = 1'b1;
        end else if (m_mode == 1) begin
            nidx = -1;
            for (int i = 0; i < 13; i++)
                if (seq[i] == int'(m_pos) && seq[(i + 1) % 13] == p) nidx = (i + 1) % 13;
            if (nidx < 0) viol = 1'b1;
            else begin
                m_idx = nidx; m_mode = 2; m_locked = 1'b1; m_dir = (nidx >= 6);
            end
            m_pos = 3'(p);
        end else begin
            nidx = (m_idx + 1) % 13;
            if (seq[nidx] != p) viol = 1'b1;
            else begin
                m_idx = nidx;
                m_dir = (nidx >= 6);
                if (nidx == 0 || nidx == 6) m_bounce = m_bounce + 8'd1;
            end
            m_pos = 3'(p);
        end
        if (viol) begin
            m_err = 1'b1; m_locked = 1'b0; m_mode = 0;
`ifdef SCROLL_MON_STICKY_ERR_EN
            m_frozen = 1'b1;
`endif
        end
    endtask

    function automatic logic [W-1:0] model_pack();
        return {m_pos, m_dir, m_locked, m_err, m_bounce};
    endfunction

    task automatic check_outputs(input string tag);
        logic [W-1:0] expv;
        logic [W-1:0] obs;
        if (exp_q.size() == 0) begin
            n_assert++; n_fail++;
            $display("FAIL %s: scoreboard empty, observed output without expectation", tag);
            return;
        end
        expv = exp_q.pop_front();
        obs  = {pos, dir, locked, err, bounce_cnt};
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed pos=%0d dir=%0d locked=%0d err=%0d cnt=%0d expected pos=%0d dir=%0d locked=%0d err=%0d cnt=%0d",
                   tag, obs[13:11], obs[10], obs[9], obs[8], obs[7:0],
                   expv[13:11], expv[10], expv[9], expv[8], expv[7:0]);
        end
        n_assert++;
        assert (bounce_cnt2 === expv[1:0]) else begin
            n_fail++;
            $error("FAIL %s_cnt2: observed %0d expected %0d", tag, bounce_cnt2, expv[1:0]);
        end
        n_assert++;
        assert ((dbg_state == 3'd0) === (m_mode == 0)) else begin
            n_fail++;
            $error("FAIL %s_sync: observed state %0d expected in_sync=%0d", tag, dbg_state, m_mode == 0);
        end
    endtask

    task automatic cycle(input logic en, input logic [7:0] pat, input string tag);
        @(negedge clk);
        sample_en  = en;
        pattern_in = pat;
        model_cycle(en, pat);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        reset      = 1'b1;
        sample_en  = en;
        pattern_in = 8'h06;
        model_reset();
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        reset     = 1'b0;
        sample_en = 1'b0;
        check_outputs("reset");
    endtask

    task automatic walk(input int start, input int n, input string tag);
        logic [7:0] t;
        for (int i = 0; i < n; i++) begin
            t = 8'h03;
            t = t << seq[(start + i) % 13];
            cycle(1'b1, t, tag);
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 8'($urandom_range(0, 255)), "gap_hold");
    endtask

    initial begin
        reset = 1'b1; sample_en = 1'b0; pattern_in = 8'h00;
        do_reset(1'b0);
        do_reset(1'b0);

        // Illegal patterns while in SYNC: no err, still SYNC
        cycle(1'b1, 8'h00, "sync_zero");
        cycle(1'b1, 8'hFF, "sync_ff");
        cycle(1'b1, 8'h05, "sync_gap");

        // Long legal run from 11000000
        walk(0, 39, "legal_run");
        n_assert++;
        assert (bounce_cnt === 8'd5) else begin
            n_fail++; $error("FAIL bounce5: observed %0d expected 5", bounce_cnt);
        end
        n_assert++;
        assert (bounce_cnt2 === 2'd1) else begin
            n_fail++; $error("FAIL wrap2: observed %0d expected 1", bounce_cnt2);
        end

        // Sparse strobes with changing pattern in between
        for (int k = 0; k < 4; k++) begin
            walk(k, 1, "gap_strobe");
            idle_gap(7);
        end

        // Illegal pattern while locked, then resume
        cycle(1'b1, 8'h28, "inject_illegal");
        cycle(1'b0, 8'h28, "err_pulse_end");
        walk(4, 4, "resume");

        // Skipped step 00110000 -> 00001100
        do_reset(1'b0);
        walk(0, 3, "pre_skip");
        cycle(1'b1, 8'h0C, "skip_step");
        n_assert++;
        assert (pos === 3'd2) else begin
            n_fail++; $error("FAIL skip_pos: observed %0d expected 2", pos);
        end
        walk(3, 3, "post_skip");

        // Top held three times
        do_reset(1'b0);
        walk(9, 5, "to_top");
        cycle(1'b1, 8'hC0, "top_triple");
        // Top without repeat
        do_reset(1'b0);
        walk(10, 3, "to_top2");
        cycle(1'b1, 8'h30, "top_norepeat");
        walk(2, 3, "after_norepeat");

        // Reset mid-run while strobing
        do_reset(1'b0);
        walk(0, 5, "pre_reset");
        do_reset(1'b1);

        // Error followed by a legal run (sticky build keeps err)
        walk(3, 4, "pre_err");
        cycle(1'b1, 8'h81, "err_then_run");
        walk(6, 6, "post_err_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
